dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipeline's load/store interface: accepts one data access at a time from the
//  MEM stage over a valid/ready request channel, performs it on a byte-addressed little-endian array and returns
//  data/ack over a valid/ready response channel after a fixed latency. Replaces the single-cycle data memory.
// PARAMETERS
//  ADDR_WIDTH   17   byte-address width; array holds 2**ADDR_WIDTH bytes, addresses wrap naturally
//  DATA_WIDTH   32   word width (fixed 32; byte/half lanes derive from it)
//  LATENCY      2    cycles from request accept to rsp_valid_o; legal range 1..15
// PORTS
//  clk_i         in   1           clock, rising edge
//  rst_i         in   1           synchronous active-high reset
//  req_valid_i   in   1           request present
//  req_ready_o   out  1           responder can accept (high only in IDLE)
//  req_we_i      in   1           1 = store, 0 = load
//  req_addr_i    in   ADDR_WIDTH  byte address
//  req_funct3_i  in   3           RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_wdata_i   in   DATA_WIDTH  store data, right-aligned (rs2)
//  rsp_valid_o   out  1           response present; held until rsp_ready_i
//  rsp_ready_i   in   1           requester takes response
//  rsp_rdata_o   out  DATA_WIDTH  load result, extended per funct3; 0 for stores and errors
//  rsp_err_o     out  1           access faulted (misaligned / illegal funct3); valid with rsp_valid_o
// BEHAVIOUR
//  - Clock clk_i; reset rst_i synchronous, active-high. Reset: state IDLE, req_ready_o=1, rsp_valid_o=0,
//    rsp_rdata_o=0, rsp_err_o=0, latency counter 0. Array contents NOT reset.
//  - Accept = req_valid_i & req_ready_o in cycle N. Request fields latched at that edge.
//  - Store commits to array at the accept edge (byte enables from addr[1:0] and size); read data sampled at the
//    same edge, so a load sees every earlier-accepted store. Loads never modify the array.
//  - FSM: IDLE -accept-> WAIT (counter=LATENCY-1) or RESP directly if LATENCY==1; WAIT decrements, at 1 -> RESP;
//    RESP holds rsp_* stable while rsp_ready_i=0; on rsp_ready_i=1 -> IDLE. rsp_valid_o first high in cycle N+LATENCY.
//  - Single outstanding request: req_ready_o=0 in WAIT and RESP, incl. the RESP cycle that completes; next accept
//    earliest in cycle N+LATENCY+1.
//  - Load extract: byte/half selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend to 32 bits.
//  - Store merge: SB writes byte lane addr[1:0] from wdata[7:0]; SH writes lanes addr[1]*2..+1 from wdata[15:0].
//  - Reset asserted in WAIT/RESP: response dropped, FSM to IDLE; a store already accepted stays committed.
//  - req_valid_i while not ready: ignored (no latch); requester must hold fields until accept.
// CONFIGURATION
//  - DMEM_ERR_EN defined: misaligned H (addr[0]) or W (addr[1:0]!=0), and funct3 011/110/111 (or 1xx on store),
//    complete with rsp_err_o=1, rsp_rdata_o=0, no array write; latency unchanged.
//  - Undefined: rsp_err_o tied 0; low address bits force-aligned (H drops addr[0], W drops addr[1:0]);
//    illegal funct3 treated as W.
// STRUCTURE
//  - dmem_pkg: typedef enum {IDLE, WAIT, RESP} dmem_state_t; funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
//    function for byte-enable generation.
//  - Sub-module dmem_sram: 4 byte-lane arrays, byte-enable synchronous write, synchronous read of the addressed word.
//  - dmem_responder holds FSM, latency counter, align/extend logic and response registers.
// TESTING
//  - Reset: hold rst_i 2 cycles -> req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
//  - SW 0xDEADBEEF @0x10, then LW @0x10, LATENCY=2, rsp_ready_i=1 -> rsp_valid_o in accept+2, rdata 0xDEADBEEF, err 0.
//  - After above: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
//  - SB 0x12 @0x11 then LW @0x10 -> 0xDEAD12EF; rsp_ready_i low 3 cycles -> rsp_* held stable, req_ready_o=0 throughout.
//  - DMEM_ERR_EN: LW @0x12 -> rsp_err_o=1, rdata 0; SW @0x11 -> err=1, word @0x10 unchanged.
//    Without macro: LW @0x12 -> err 0, returns word @0x10.
//  - rst_i pulsed in WAIT after LW -> no rsp_valid_o; next LW accepted in first cycle after reset and completes.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, funct3 encodings and lane helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } dmem_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned WORD_W    = NUM_LANES * LANE_W;
    localparam int unsigned CNT_W     = 4;

    // Byte-lane enables for an access of the given size at the given (already aligned) lane offset.
    function automatic logic [NUM_LANES-1:0] byte_en(dmem_size_t sz, logic [1:0] off);
        logic [NUM_LANES-1:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Pick the addressed byte/half out of a word and sign- or zero-extend it.
    function automatic logic [WORD_W-1:0] load_extend(logic [WORD_W-1:0] word, logic [1:0] off,
                                                      dmem_size_t sz, logic uns);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [WORD_W-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_B:    r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_H:    r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: four byte-lane arrays with per-lane write enable and a registered read of the addressed word.
module dmem_sram
    import dmem_pkg::*;
#(
    parameter int unsigned WORD_AW = 15
) (
    input  logic                 clk_i,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [NUM_LANES-1:0] be_i,
    input  logic [WORD_AW-1:0]   addr_i,
    input  logic [WORD_W-1:0]    wdata_i,
    output logic [WORD_W-1:0]    rdata_o
);

    localparam int unsigned DEPTH = 1 << WORD_AW;

    logic [LANE_W-1:0] rd_lane [NUM_LANES];

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [LANE_W-1:0] mem_q [DEPTH];
        logic [LANE_W-1:0] rd_q;

        // Lane storage: byte-enabled write and read of the addressed byte on the same enable.
        always_ff @(posedge clk_i) begin
            if (en_i) begin
                if (we_i && be_i[l]) begin
                    mem_q[addr_i] <= wdata_i[l*LANE_W +: LANE_W];
                end
                rd_q <= mem_q[addr_i];
            end
        end

        assign rd_lane[l] = rd_q;
    end

    assign rdata_o = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready load/store responder over a byte-addressed little-endian array with fixed latency.
// Optional macro DMEM_ERR_EN: misaligned or illegal-funct3 accesses complete with rsp_err_o=1 and no write;
// without it, low address bits are dropped to force alignment and illegal funct3 behaves as a word access.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 32,   // fixed at 32; lanes are derived from it
    parameter int unsigned LATENCY    = 2     // 1..15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int unsigned WORD_AW = ADDR_WIDTH - 2;

    dmem_state_t       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              pend_err_q;
    logic              ld_q;
    logic              uns_q;
    dmem_size_t        size_q;
    logic [1:0]        off_q;

    logic              accept;
    dmem_size_t        acc_size;
    logic              acc_uns;
    logic [1:0]        acc_off;
    logic              acc_err;
    logic [WORD_W-1:0] wdata_rep;
    logic [WORD_W-1:0] sram_rdata;

    assign accept = req_valid_i & req_ready_q;

    // Decode access size/sign; anything not a legal encoding falls back to a word access.
    always_comb begin
        acc_size = SZ_W;
        acc_uns  = 1'b0;
        case (req_funct3_i)
            F3_B:    acc_size = SZ_B;
            F3_H:    acc_size = SZ_H;
            F3_BU:   begin acc_size = SZ_B; acc_uns = 1'b1; end
            F3_HU:   begin acc_size = SZ_H; acc_uns = 1'b1; end
            default: acc_size = SZ_W;
        endcase
        if (req_we_i && req_funct3_i[2]) begin
            acc_size = SZ_W;
            acc_uns  = 1'b0;
        end
    end

    // Lane offset with the size-implied low bits dropped; identical to the raw bits for aligned accesses.
    always_comb begin
        acc_off = req_addr_i[1:0];
        case (acc_size)
            SZ_H:    acc_off = {req_addr_i[1], 1'b0};
            SZ_W:    acc_off = 2'b00;
            default: acc_off = req_addr_i[1:0];
        endcase
    end

`ifdef DMEM_ERR_EN
    logic f3_ok;
    logic misalign;
    assign f3_ok    = req_we_i ? (req_funct3_i == F3_B || req_funct3_i == F3_H || req_funct3_i == F3_W)
                               : (req_funct3_i == F3_B  || req_funct3_i == F3_H || req_funct3_i == F3_W ||
                                  req_funct3_i == F3_BU || req_funct3_i == F3_HU);
    assign misalign = ((acc_size == SZ_H) && req_addr_i[0]) ||
                      ((acc_size == SZ_W) && (req_addr_i[1:0] != 2'b00));
    assign acc_err  = ~f3_ok | misalign;
`else
    assign acc_err  = 1'b0;
`endif

    // Replicate store data across lanes so the byte enables alone select what lands.
    always_comb begin
        wdata_rep = req_wdata_i;
        case (acc_size)
            SZ_B:    wdata_rep = {4{req_wdata_i[7:0]}};
            SZ_H:    wdata_rep = {2{req_wdata_i[15:0]}};
            default: wdata_rep = req_wdata_i;
        endcase
    end

    dmem_sram #(
        .WORD_AW (WORD_AW)
    ) u_sram (
        .clk_i   (clk_i),
        .en_i    (accept),
        .we_i    (req_we_i & ~acc_err),
        .be_i    (byte_en(acc_size, acc_off)),
        .addr_i  (req_addr_i[ADDR_WIDTH-1:2]),
        .wdata_i (wdata_rep),
        .rdata_o (sram_rdata)
    );

    // Request/response FSM with latency counter; single outstanding access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            pend_err_q  <= 1'b0;
            ld_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= SZ_W;
            off_q       <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        pend_err_q  <= acc_err;
                        ld_q        <= ~req_we_i & ~acc_err;
                        uns_q       <= acc_uns;
                        size_q      <= acc_size;
                        off_q       <= acc_off;
                        if (LATENCY == 1) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= acc_err;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= RESP;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= pend_err_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        ld_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    // Load data comes straight from the registered array word; zero for stores, errors and when idle.
    assign rsp_rdata_o = (rsp_valid_q && ld_q) ? DATA_WIDTH'(load_extend(sram_rdata, off_q, size_q, uns_q))
                                               : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store vectors against dmem_responder (LATENCY=2); DMEM_ERR_EN selects error checks.
module tb_dmem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [16:0] req_addr_i = '0;
    logic [2:0]  req_funct3_i = 3'b010;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int unsigned n_vec = 0;
    int unsigned n_mis = 0;

    dmem_responder #(
        .ADDR_WIDTH (17),
        .DATA_WIDTH (32),
        .LATENCY    (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_funct3_i (req_funct3_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access: present request, wait for accept, wait for response; drain it unless hold is set.
    task automatic access(input logic we, input logic [16:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int guard;
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_addr_i   = addr;
        req_funct3_i = f3;
        req_wdata_i  = wd;
        guard = 0;
        while (!req_ready_o && guard < 50) begin
            @(posedge clk_i); #1;
            guard++;
        end
        if (guard >= 50) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk("busy_after_accept", {31'b0, req_ready_o}, 32'd0);
        lat = 1;
        while (!rsp_valid_o && lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
        end
        rd = rsp_rdata_o;
        er = rsp_err_o;
        if (!hold) begin
            @(posedge clk_i); #1;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        // reset held two cycles
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
        chk("rst_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_err",   {31'b0, rsp_err_o},   32'd0);

        // word store then word load with latency check
        access(1'b1, 17'h10, 3'b010, 32'hDEADBEEF, 1'b0, rd, er, lat);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_err", {31'b0, er}, 32'd0);
        chk("idle_ready", {31'b0, req_ready_o}, 32'd1);
        access(1'b0, 17'h10, 3'b010, 32'h0, 1'b0, rd, er, lat);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'b0, er}, 32'd0);

        // sub-word loads with sign/zero extension
        access(1'b0, 17'h13, 3'b000, 32'h0, 1'b0, rd, er, lat);
        chk("lb_13", rd, 32'hFFFFFFDE);
        access(1'b0, 17'h13, 3'b100, 32'h0, 1'b0, rd, er, lat);
        chk("lbu_13", rd, 32'h000000DE);
        access(1'b0, 17'h12, 3'b001, 32'h0, 1'b0, rd, er, lat);
        chk("lh_12", rd, 32'hFFFFDEAD);
        access(1'b0, 17'h10, 3'b101, 32'h0, 1'b0, rd, er, lat);
        chk("lhu_10", rd, 32'h0000BEEF);
        access(1'b0, 17'h11, 3'b000, 32'h0, 1'b0, rd, er, lat);
        chk("lb_11", rd, 32'hFFFFFFBE);

        // byte store merge, then held response
        access(1'b1, 17'h11, 3'b000, 32'hFFFFFF12, 1'b0, rd, er, lat);
        rsp_ready_i = 1'b0;
        access(1'b0, 17'h10, 3'b010, 32'h0, 1'b1, rd, er, lat);
        chk("sb_merge", rd, 32'hDEAD12EF);
        chk("hold_lat", 32'(lat), 32'd2);
        chk("hold_ready0", {31'b0, req_ready_o}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i); #1;
            chk("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
            chk("hold_rdata", rsp_rdata_o, 32'hDEAD12EF);
            chk("hold_ready", {31'b0, req_ready_o}, 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("release_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("release_ready", {31'b0, req_ready_o}, 32'd1);

        // half store into upper lanes
        access(1'b1, 17'h14, 3'b010, 32'h00000000, 1'b0, rd, er, lat);
        access(1'b1, 17'h16, 3'b001, 32'hABCD8001, 1'b0, rd, er, lat);
        access(1'b0, 17'h14, 3'b010, 32'h0, 1'b0, rd, er, lat);
        chk("sh_word", rd, 32'h80010000);
        access(1'b0, 17'h16, 3'b001, 32'h0, 1'b0, rd, er, lat);
        chk("lh_16", rd, 32'hFFFF8001);
        access(1'b0, 17'h16, 3'b101, 32'h0, 1'b0, rd, er, lat);
        chk("lhu_16", rd, 32'h00008001);

        // top of the address space
        access(1'b1, 17'h1FFFC, 3'b010, 32'h01234567, 1'b0, rd, er, lat);
        access(1'b0, 17'h1FFFF, 3'b100, 32'h0, 1'b0, rd, er, lat);
        chk("lbu_top", rd, 32'h00000001);

`ifdef DMEM_ERR_EN
        access(1'b0, 17'h12, 3'b010, 32'h0, 1'b0, rd, er, lat);
        chk("mis_lw_err", {31'b0, er}, 32'd1);
        chk("mis_lw_rdata", rd, 32'd0);
        chk("mis_lw_lat", 32'(lat), 32'd2);
        access(1'b1, 17'h11, 3'b010, 32'h55555555, 1'b0, rd, er, lat);
        chk("mis_sw_err", {31'b0, er}, 32'd1);
        access(1'b0, 17'h10, 3'b011, 32'h0, 1'b0, rd, er, lat);
        chk("bad_f3_err", {31'b0, er}, 32'd1);
        chk("bad_f3_rdata", rd, 32'd0);
        access(1'b0, 17'h10, 3'b010, 32'h0, 1'b0, rd, er, lat);
        chk("mis_sw_nowrite", rd, 32'hDEAD12EF);
        chk("ok_err", {31'b0, er}, 32'd0);
`else
        access(1'b0, 17'h12, 3'b010, 32'h0, 1'b0, rd, er, lat);
        chk("align_lw_rdata", rd, 32'hDEAD12EF);
        chk("align_lw_err", {31'b0, er}, 32'd0);
        access(1'b0, 17'h13, 3'b001, 32'h0, 1'b0, rd, er, lat);
        chk("align_lh", rd, 32'hFFFFDEAD);
        access(1'b0, 17'h10, 3'b011, 32'h0, 1'b0, rd, er, lat);
        chk("f3_as_word", rd, 32'hDEAD12EF);
`endif

        // reset during WAIT drops the response
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_addr_i   = 17'h10;
        req_funct3_i = 3'b010;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("wait_rst_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("wait_rst_ready", {31'b0, req_ready_o}, 32'd1);
        access(1'b0, 17'h10, 3'b010, 32'h0, 1'b0, rd, er, lat);
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk("post_rst_rdata", rd, 32'hDEAD12EF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
